// File: rtl/sdr_toggle_arbiter_if.sv
// Memory-side bus between the toggle arbiter and the SDRAM controller:
// a valid/ready command channel plus a read-data beat channel.
interface sdr_toggle_arbiter_if #(
  parameter int ADDR_W = 26
);
  logic [ADDR_W:1] mem_addr;
  logic [15:0]     mem_wdata;
  logic [1:0]      mem_be;
  logic            mem_we;
  logic            mem_burst2;
  logic            mem_cmd_valid;
  logic            mem_cmd_ready;
  logic [15:0]     mem_rdata;
  logic            mem_rvalid;

  // Arbiter side: issues commands, consumes read beats.
  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_be,
    output mem_we,
    output mem_burst2,
    output mem_cmd_valid,
    input  mem_cmd_ready,
    input  mem_rdata,
    input  mem_rvalid
  );

  // Memory controller side: accepts commands, returns read beats.
  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    input  mem_we,
    input  mem_burst2,
    input  mem_cmd_valid,
    output mem_cmd_ready,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/sdr_toggle_arbiter.sv
// Two-client toggle-handshake arbiter in front of a single SDRAM command port.
// CPU issues 16-bit reads/writes; the tile fetcher (SCN) issues 32-bit reads
// as a two-beat burst. One command in flight; round robin when both pend.
module sdr_toggle_arbiter #(
  parameter int ADDR_W = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W:1]      sdr_cpu_addr,
  input  logic [15:0]          sdr_cpu_data,
  input  logic [1:0]           sdr_cpu_be,
  input  logic                 sdr_cpu_rw,
  input  logic                 sdr_cpu_req,
  output logic                 sdr_cpu_ack,
  output logic [15:0]          sdr_cpu_q,
  input  logic [ADDR_W:1]      sdr_scn_main_addr,
  input  logic                 sdr_scn_main_req,
  output logic                 sdr_scn_main_ack,
  output logic [31:0]          sdr_scn_main_q,
  sdr_toggle_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            grant_scn_reg, grant_scn_next;  // port currently being served
  logic            last_scn_reg, last_scn_next;    // port granted most recently
  logic [ADDR_W:1] addr_reg, addr_next;
  logic [15:0]     wdata_reg, wdata_next;
  logic [1:0]      be_reg, be_next;
  logic            we_reg, we_next;
  logic            burst2_reg, burst2_next;
  logic            beat_reg, beat_next;
  logic            cpu_ack_reg, cpu_ack_next;
  logic            scn_ack_reg, scn_ack_next;
  logic [15:0]     cpu_q_reg, cpu_q_next;
  logic [31:0]     scn_q_reg, scn_q_next;

  logic cpu_pending;
  logic scn_pending;

  assign cpu_pending = sdr_cpu_req ^ cpu_ack_reg;
  assign scn_pending = sdr_scn_main_req ^ scn_ack_reg;

  // Grant selection, command handshake and read-beat collection.
  always_comb begin
    state_next     = state_reg;
    grant_scn_next = grant_scn_reg;
    last_scn_next  = last_scn_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    be_next        = be_reg;
    we_next        = we_reg;
    burst2_next    = burst2_reg;
    beat_next      = beat_reg;
    cpu_ack_next   = cpu_ack_reg;
    scn_ack_next   = scn_ack_reg;
    cpu_q_next     = cpu_q_reg;
    scn_q_next     = scn_q_reg;

    case (state_reg)
      IDLE: begin
        // CPU wins when alone, or when both pend and SCN had the last turn.
        if (cpu_pending && (!scn_pending || last_scn_reg)) begin
          addr_next      = sdr_cpu_addr;
          wdata_next     = sdr_cpu_data;
          be_next        = sdr_cpu_be;
          we_next        = ~sdr_cpu_rw;
          burst2_next    = 1'b0;
          grant_scn_next = 1'b0;
          last_scn_next  = 1'b0;
          state_next     = CMD;
        end else if (scn_pending) begin
          addr_next      = sdr_scn_main_addr;
          wdata_next     = 16'h0000;
          be_next        = 2'b11;
          we_next        = 1'b0;
          burst2_next    = 1'b1;
          grant_scn_next = 1'b1;
          last_scn_next  = 1'b1;
          state_next     = CMD;
        end
      end

      CMD: begin
        if (mem.mem_cmd_ready) begin
          if (we_reg) begin
            // Only CPU can write; a write is complete once accepted.
            cpu_ack_next = ~cpu_ack_reg;
            state_next   = IDLE;
          end else begin
            beat_next  = 1'b0;
            state_next = RDATA;
          end
        end
      end

      RDATA: begin
        if (mem.mem_rvalid) begin
          if (!grant_scn_reg) begin
            cpu_q_next   = mem.mem_rdata;
            cpu_ack_next = ~cpu_ack_reg;
            state_next   = IDLE;
          end else if (!beat_reg) begin
            scn_q_next[15:0] = mem.mem_rdata;
            beat_next        = 1'b1;
          end else begin
            scn_q_next[31:16] = mem.mem_rdata;
            scn_ack_next      = ~scn_ack_reg;
            beat_next         = 1'b0;
            state_next        = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      grant_scn_reg <= 1'b0;
      last_scn_reg  <= 1'b1;
      addr_reg      <= '0;
      wdata_reg     <= 16'h0000;
      be_reg        <= 2'b00;
      we_reg        <= 1'b0;
      burst2_reg    <= 1'b0;
      beat_reg      <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      scn_ack_reg   <= 1'b0;
      cpu_q_reg     <= 16'h0000;
      scn_q_reg     <= 32'h0000_0000;
    end else begin
      state_reg     <= state_next;
      grant_scn_reg <= grant_scn_next;
      last_scn_reg  <= last_scn_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_reg        <= be_next;
      we_reg        <= we_next;
      burst2_reg    <= burst2_next;
      beat_reg      <= beat_next;
      cpu_ack_reg   <= cpu_ack_next;
      scn_ack_reg   <= scn_ack_next;
      cpu_q_reg     <= cpu_q_next;
      scn_q_reg     <= scn_q_next;
    end
  end

  assign mem.mem_addr      = addr_reg;
  assign mem.mem_wdata     = wdata_reg;
  assign mem.mem_be        = be_reg;
  assign mem.mem_we        = we_reg;
  assign mem.mem_burst2    = burst2_reg;
  assign mem.mem_cmd_valid = (state_reg == CMD);

  assign sdr_cpu_ack      = cpu_ack_reg;
  assign sdr_cpu_q        = cpu_q_reg;
  assign sdr_scn_main_ack = scn_ack_reg;
  assign sdr_scn_main_q   = scn_q_reg;

endmodule

// File: tb/tb_sdr_toggle_arbiter.sv
// Bench for sdr_toggle_arbiter: clients push expected commands/responses into
// queues; a negedge memory responder/monitor pops and compares them.
module tb_sdr_toggle_arbiter;
  localparam int AW = 26;

  typedef struct packed {
    logic [AW:1] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        we;
    logic        burst2;
  } cmd_t;

  typedef struct {
    logic        v;
    logic [15:0] data;
    logic        last;
    logic        scn;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [AW:1] sdr_cpu_addr;
  logic [15:0] sdr_cpu_data;
  logic [1:0]  sdr_cpu_be;
  logic        sdr_cpu_rw;
  logic        sdr_cpu_req;
  logic        sdr_cpu_ack;
  logic [15:0] sdr_cpu_q;
  logic [AW:1] sdr_scn_main_addr;
  logic        sdr_scn_main_req;
  logic        sdr_scn_main_ack;
  logic [31:0] sdr_scn_main_q;

  sdr_toggle_arbiter_if #(.ADDR_W(AW)) mif ();

  sdr_toggle_arbiter #(.ADDR_W(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .sdr_cpu_addr     (sdr_cpu_addr),
    .sdr_cpu_data     (sdr_cpu_data),
    .sdr_cpu_be       (sdr_cpu_be),
    .sdr_cpu_rw       (sdr_cpu_rw),
    .sdr_cpu_req      (sdr_cpu_req),
    .sdr_cpu_ack      (sdr_cpu_ack),
    .sdr_cpu_q        (sdr_cpu_q),
    .sdr_scn_main_addr(sdr_scn_main_addr),
    .sdr_scn_main_req (sdr_scn_main_req),
    .sdr_scn_main_ack (sdr_scn_main_ack),
    .sdr_scn_main_q   (sdr_scn_main_q),
    .mem              (mif)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  cmd_t        exp_cmd_cpu[$];
  cmd_t        exp_cmd_scn[$];
  logic [15:0] exp_rsp_cpu[$];
  logic [31:0] exp_rsp_scn[$];
  beat_t       beats[$];
  int          grant_log[$];
  logic [15:0] ref_mem[int];
  logic [15:0] resp_mem[int];
  logic [15:0] exp_cpu_q = 16'h0;
  logic [31:0] exp_scn_q = 32'h0;
  int          stall_cfg = 0;
  int          gap0_cfg = 0;
  int          gap1_cfg = 0;
  bit          inj_pending = 1'b0;
  logic [15:0] inj_data = 16'h0;
  int          beats_driven = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s", nm, what);
  endtask

  // Memory contents before any write: a fixed scramble of the word address.
  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] w;
    w = old;
    if (be[0]) w[7:0] = d[7:0];
    if (be[1]) w[15:8] = d[15:8];
    return w;
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] resp_rd(input int a);
    return resp_mem.exists(a) ? resp_mem[a] : init_val(a);
  endfunction

  // Reference model: CPU sees a plain word memory, SCN reads two consecutive words.
  task automatic cpu_txn(input logic rw, input logic [AW:1] a, input logic [15:0] d,
                         input logic [1:0] be, input bit lat_chk);
    cmd_t c;
    int   n;
    c = {a, d, be, ~rw, 1'b0};
    if (rw) exp_cpu_q = ref_rd(int'(a));
    else ref_mem[int'(a)] = merge(ref_rd(int'(a)), d, be);
    exp_cmd_cpu.push_back(c);
    exp_rsp_cpu.push_back(exp_cpu_q);
    @(posedge clk); #1;
    sdr_cpu_addr = a;
    sdr_cpu_data = d;
    sdr_cpu_be   = be;
    sdr_cpu_rw   = rw;
    sdr_cpu_req  = ~sdr_cpu_req;
    if (lat_chk) begin
      @(negedge clk);
      chk("grant_lat_idle", mif.mem_cmd_valid, 1'b0);
      @(negedge clk);
      chk("grant_lat_cmd", mif.mem_cmd_valid, 1'b1);
    end
    n = 0;
    while (sdr_cpu_ack !== sdr_cpu_req && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("cpu_timeout", "no ack within 400 cycles");
  endtask

  task automatic scn_txn(input logic [AW:1] a);
    cmd_t        c;
    logic [AW:1] a1;
    int          n;
    a1 = a + 1'b1;
    c = {a, 16'h0000, 2'b11, 1'b0, 1'b1};
    exp_scn_q = {ref_rd(int'(a1)), ref_rd(int'(a))};
    exp_cmd_scn.push_back(c);
    exp_rsp_scn.push_back(exp_scn_q);
    @(posedge clk); #1;
    sdr_scn_main_addr = a;
    sdr_scn_main_req  = ~sdr_scn_main_req;
    n = 0;
    while (sdr_scn_main_ack !== sdr_scn_main_req && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail("scn_timeout", "no ack within 400 cycles");
  endtask

  // Memory responder and response monitor, both stepping on the falling edge.
  initial begin : responder
    logic        prev_cpu_ack, prev_scn_ack, cpu_chg, scn_chg;
    logic [15:0] prev_cpu_q;
    logic [31:0] prev_scn_q;
    logic        chk_cpu, chk_scn, stall_started, have_snap;
    int          stall_left, g;
    cmd_t        snap, cur, e;
    beat_t       b;
    logic [AW:1] a1;
    chk_cpu = 1'b0; chk_scn = 1'b0; stall_started = 1'b0; have_snap = 1'b0;
    stall_left = 0; snap = '0;
    prev_cpu_ack = 1'b0; prev_scn_ack = 1'b0; prev_cpu_q = 16'h0; prev_scn_q = 32'h0;
    mif.mem_cmd_ready = 1'b0;
    mif.mem_rvalid    = 1'b0;
    mif.mem_rdata     = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        beats.delete();
        exp_cmd_cpu.delete(); exp_cmd_scn.delete();
        exp_rsp_cpu.delete(); exp_rsp_scn.delete();
        chk_cpu = 1'b0; chk_scn = 1'b0; stall_started = 1'b0; have_snap = 1'b0;
        mif.mem_cmd_ready = 1'b0;
        mif.mem_rvalid    = 1'b0;
        prev_cpu_ack = sdr_cpu_ack; prev_scn_ack = sdr_scn_main_ack;
        prev_cpu_q   = sdr_cpu_q;   prev_scn_q   = sdr_scn_main_q;
      end else begin
        // Response side.
        cpu_chg = (sdr_cpu_ack !== prev_cpu_ack);
        scn_chg = (sdr_scn_main_ack !== prev_scn_ack);
        if (chk_cpu) chk("cpu_ack_timing", cpu_chg, 1'b1);
        if (chk_scn) chk("scn_ack_timing", scn_chg, 1'b1);
        chk_cpu = 1'b0;
        chk_scn = 1'b0;
        if (cpu_chg) begin
          if (exp_rsp_cpu.size() == 0) fail("cpu_ack_unexpected", "ack toggle with nothing pending");
          else chk("cpu_q", sdr_cpu_q, exp_rsp_cpu.pop_front());
        end else begin
          chk("cpu_q_hold", sdr_cpu_q, prev_cpu_q);
        end
        if (scn_chg) begin
          if (exp_rsp_scn.size() == 0) fail("scn_ack_unexpected", "ack toggle with nothing pending");
          else chk("scn_q", sdr_scn_main_q, exp_rsp_scn.pop_front());
        end else begin
          chk("scn_q_hi_hold", sdr_scn_main_q[31:16], prev_scn_q[31:16]);
        end
        prev_cpu_ack = sdr_cpu_ack; prev_scn_ack = sdr_scn_main_ack;
        prev_cpu_q   = sdr_cpu_q;   prev_scn_q   = sdr_scn_main_q;

        // Read-data beats (one queue entry per cycle, bubbles have v=0).
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 16'($urandom);
        if (inj_pending) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = inj_data;
          inj_pending    = 1'b0;
        end else if (beats.size() > 0) begin
          b = beats.pop_front();
          if (b.v) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = b.data;
            beats_driven++;
            if (b.last) begin
              if (b.scn) chk_scn = 1'b1;
              else chk_cpu = 1'b1;
            end
          end
        end

        // Command side with optional back-pressure.
        mif.mem_cmd_ready = 1'b0;
        if (mif.mem_cmd_valid) begin
          cur = {mif.mem_addr, mif.mem_wdata, mif.mem_be, mif.mem_we, mif.mem_burst2};
          if (have_snap) chk("cmd_stable", cur, snap);
          if (!stall_started) begin
            stall_started = 1'b1;
            stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
          end
          if (stall_left > 0) begin
            stall_left--;
            snap = cur;
            have_snap = 1'b1;
          end else begin
            mif.mem_cmd_ready = 1'b1;
            stall_started = 1'b0;
            have_snap = 1'b0;
            $display("txn %s addr=%h wdata=%h be=%b we=%b", cur.burst2 ? "SCN" : "CPU",
                     cur.addr, cur.wdata, cur.be, cur.we);
            if (cur.burst2) begin
              grant_log.push_back(1);
              if (exp_cmd_scn.size() == 0) fail("scn_cmd_unexpected", "command with no request");
              else begin e = exp_cmd_scn.pop_front(); chk("scn_cmd", cur, e); end
            end else begin
              grant_log.push_back(0);
              if (exp_cmd_cpu.size() == 0) fail("cpu_cmd_unexpected", "command with no request");
              else begin e = exp_cmd_cpu.pop_front(); chk("cpu_cmd", cur, e); end
            end
            if (cur.we) begin
              resp_mem[int'(cur.addr)] = merge(resp_rd(int'(cur.addr)), cur.wdata, cur.be);
              chk_cpu = 1'b1;
            end else begin
              g = (gap0_cfg < 0) ? int'($urandom_range(0, 3)) : gap0_cfg;
              repeat (g) begin b.v = 1'b0; b.data = 16'h0; b.last = 1'b0; b.scn = 1'b0; beats.push_back(b); end
              b.v = 1'b1; b.data = resp_rd(int'(cur.addr)); b.last = ~cur.burst2; b.scn = cur.burst2;
              beats.push_back(b);
              if (cur.burst2) begin
                a1 = cur.addr + 1'b1;
                g = (gap1_cfg < 0) ? int'($urandom_range(0, 3)) : gap1_cfg;
                repeat (g) begin b.v = 1'b0; b.data = 16'h0; b.last = 1'b0; b.scn = 1'b0; beats.push_back(b); end
                b.v = 1'b1; b.data = resp_rd(int'(a1)); b.last = 1'b1; b.scn = 1'b1;
                beats.push_back(b);
              end
            end
          end
        end else begin
          stall_started = 1'b0;
          have_snap = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish after 50000 cycles want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] iv;
    int          bd, n;
    reset = 1'b1;
    sdr_cpu_addr = '0; sdr_cpu_data = 16'h0; sdr_cpu_be = 2'b00; sdr_cpu_rw = 1'b1;
    sdr_cpu_req = 1'b0; sdr_scn_main_addr = '0; sdr_scn_main_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ack", sdr_cpu_ack, 1'b0);
    chk("rst_scn_ack", sdr_scn_main_ack, 1'b0);
    chk("rst_cpu_q", sdr_cpu_q, 16'h0);
    chk("rst_scn_q", sdr_scn_main_q, 32'h0);
    chk("rst_valid", mif.mem_cmd_valid, 1'b0);
    chk("rst_we", mif.mem_we, 1'b0);
    chk("rst_burst2", mif.mem_burst2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // CPU read, immediate accept, data one cycle later.
    ref_mem[16] = 16'hBEEF; resp_mem[16] = 16'hBEEF;
    stall_cfg = 0; gap0_cfg = 0; gap1_cfg = 0;
    cpu_txn(1'b1, 26'h10, 16'h0, 2'b11, 1'b1);
    @(negedge clk);
    chk("t1_cpu_q", sdr_cpu_q, 16'hBEEF);

    // CPU write under 3 cycles of back-pressure, then read back.
    stall_cfg = 3;
    cpu_txn(1'b0, 26'h100000, 16'h1234, 2'b01, 1'b0);
    stall_cfg = 0;
    cpu_txn(1'b1, 26'h100000, 16'h0, 2'b11, 1'b0);
    @(negedge clk);
    iv = init_val(32'h100000);
    chk("t2_readback", sdr_cpu_q, {iv[15:8], 8'h34});

    // SCN burst read with a 2-cycle gap between beats.
    ref_mem[32'h300] = 16'h5678; resp_mem[32'h300] = 16'h5678;
    ref_mem[32'h301] = 16'h1234; resp_mem[32'h301] = 16'h1234;
    gap1_cfg = 2;
    scn_txn(26'h300);
    @(negedge clk);
    chk("t3_scn_q", sdr_scn_main_q, 32'h12345678);

    // Simultaneous toggles, each client re-toggles on its ack: grants alternate.
    gap1_cfg = 0;
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) cpu_txn(1'b1, 26'(i), 16'h0, 2'b11, 1'b0);
      for (int i = 0; i < 4; i++) scn_txn(26'(32'h200 + 2 * i));
    join
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("rr_order_%0d", i), grant_log[i], i % 2);

    // After a CPU grant, a simultaneous pair goes SCN first.
    cpu_txn(1'b0, 26'h5, 16'hA55A, 2'b11, 1'b0);
    grant_log.delete();
    fork
      cpu_txn(1'b1, 26'h5, 16'h0, 2'b11, 1'b0);
      scn_txn(26'h210);
    join
    chk("rr_after_cpu_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("rr_after_cpu_first", grant_log[0], 1);
      chk("rr_after_cpu_second", grant_log[1], 0);
    end

    // Stray read beat while idle.
    inj_data = 16'hDEAD; inj_pending = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_cpu_q", sdr_cpu_q, exp_cpu_q);
    chk("stray_scn_q", sdr_scn_main_q, exp_scn_q);
    chk("stray_cpu_ack", sdr_cpu_ack, sdr_cpu_req);
    chk("stray_scn_ack", sdr_scn_main_ack, sdr_scn_main_req);

    // Reset after the first SCN beat, then a stray beat.
    gap0_cfg = 0; gap1_cfg = 5;
    exp_cmd_scn.push_back({26'h400, 16'h0000, 2'b11, 1'b0, 1'b1});
    bd = beats_driven;
    @(posedge clk); #1;
    sdr_scn_main_addr = 26'h400;
    sdr_scn_main_req = ~sdr_scn_main_req;
    n = 0;
    while (beats_driven == bd && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("rst_beat0_timeout", "no first beat within 50 cycles");
    @(posedge clk); #1;
    reset = 1'b1;
    sdr_cpu_req = 1'b0; sdr_scn_main_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    exp_cpu_q = 16'h0; exp_scn_q = 32'h0;
    inj_data = 16'hCAFE; inj_pending = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_cpu_ack", sdr_cpu_ack, 1'b0);
    chk("midrst_scn_ack", sdr_scn_main_ack, 1'b0);
    chk("midrst_cpu_q", sdr_cpu_q, 16'h0);
    chk("midrst_scn_q", sdr_scn_main_q, 32'h0);
    chk("midrst_valid", mif.mem_cmd_valid, 1'b0);

    // Randomized concurrent traffic with random back-pressure and beat gaps.
    stall_cfg = -1; gap0_cfg = -1; gap1_cfg = -1;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        cpu_txn(1'($urandom_range(0, 1)), 26'($urandom_range(0, 31)), 16'($urandom),
                2'($urandom_range(0, 3)), 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        scn_txn(26'($urandom_range(32'h200, 32'h21F)));
      end
    join

    repeat (10) @(negedge clk);
    chk("leftover_rsp", exp_rsp_cpu.size() + exp_rsp_scn.size(), 0);
    chk("leftover_cmd", exp_cmd_cpu.size() + exp_cmd_scn.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdr_toggle_arbiter.md
SDR_TOGGLE_ARBITER -- requirements
Module: sdr_toggle_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 26, top index of word address buses ([ADDR_W:1]).
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: sdr_cpu_addr  in  ADDR_W  CPU word address.
REQ-005 SHALL have ports: sdr_cpu_data  in  16  CPU write data.
REQ-006 SHALL have ports: sdr_cpu_be  in  2  CPU byte enables, bit1 = [15:8].
REQ-007 SHALL have ports: sdr_cpu_rw  in  1  1 = read, 0 = write.
REQ-008 SHALL have ports: sdr_cpu_req  in  1  CPU toggle request.
REQ-009 SHALL have ports: sdr_cpu_ack  out  1  CPU toggle acknowledge.
REQ-010 SHALL have ports: sdr_cpu_q  out  16  CPU read data.
REQ-011 SHALL have ports: sdr_scn_main_addr  in  ADDR_W  tile ROM word address; sdr_scn_main_req  in  1; sdr_scn_main_ack  out  1; sdr_scn_main_q  out  32.
REQ-012 SHALL have ports: mem_addr  out  ADDR_W; mem_wdata  out  16; mem_be  out  2; mem_we  out  1; mem_burst2  out  1  two-beat read; mem_cmd_valid  out  1; mem_cmd_ready  in  1; mem_rdata  in  16; mem_rvalid  in  1.

Function
REQ-013 SHALL treat a port as pending when its req differs from its ack.
REQ-014 SHALL use states IDLE, CMD, RDATA; at most one command in flight.
REQ-015 In IDLE with one port pending, SHALL grant it; with both pending, SHALL grant the port not granted last (round robin); last-grant register resets to SCN so CPU wins first.
REQ-016 On grant SHALL latch address, data, be, rw into command registers and enter CMD with mem_cmd_valid = 1 on the next cycle (1-cycle grant latency).
REQ-017 CPU command: mem_we = ~rw, mem_be = be, mem_burst2 = 0; SCN command: mem_we = 0, mem_be = 2'b11, mem_burst2 = 1, mem_wdata = 0.
REQ-018 Command outputs SHALL be held stable while mem_cmd_valid & ~mem_cmd_ready.
REQ-019 On mem_cmd_valid & mem_cmd_ready: CPU write SHALL toggle sdr_cpu_ack on that edge and return to IDLE; reads SHALL go to RDATA, deasserting mem_cmd_valid.
REQ-020 In RDATA a 1-bit beat counter SHALL count mem_rvalid; CPU read completes on beat 0, SCN read on beat 1.
REQ-021 SCN beat 0 SHALL load sdr_scn_main_q[15:0], beat 1 sdr_scn_main_q[31:16]; CPU beat 0 SHALL load sdr_cpu_q.
REQ-022 On the final-beat edge SHALL toggle the granted port's ack, load the data, and return to IDLE; ack visible the cycle after final rvalid.
REQ-023 q outputs SHALL change only on the granted port's data beats, otherwise hold last value.
REQ-024 mem_rvalid outside RDATA SHALL be ignored.
REQ-025 A req toggle arriving during service of the other port SHALL wait, be granted next IDLE cycle.
REQ-026 Back-to-back: new request seen in IDLE the cycle after completion; no extra idle cycle.
REQ-027 A client toggling req again before its ack toggles is a protocol violation; behaviour undefined, not checked.

Reset
REQ-028 On reset: state IDLE, sdr_cpu_ack = 0, sdr_scn_main_ack = 0, sdr_cpu_q = 0, sdr_scn_main_q = 0, mem_cmd_valid = 0, mem_we = 0, mem_burst2 = 0, beat counter 0, last grant = SCN.
REQ-029 Reset mid-operation SHALL abandon the in-flight command without acking; subsequent stray rvalid beats ignored per REQ-024.

Verification
REQ-030 CPU read addr 0x000010, cmd_ready immediate, rdata 0xBEEF one cycle later -> one cmd with burst2=0, we=0; sdr_cpu_q = 0xBEEF and ack toggles the cycle after rvalid.
REQ-031 CPU write addr 0x100000 data 0x1234 be 2'b01, cmd_ready held low 3 cycles -> cmd outputs stable 3 cycles, ack toggles on accept edge, no RDATA state.
REQ-032 SCN read, beats 0x5678 then 0x1234 with 2-cycle gap -> sdr_scn_main_q = 0x12345678, ack toggles once after second beat.
REQ-033 CPU and SCN toggle same cycle, both re-toggle on each ack for 4 rounds -> grants alternate CPU, SCN, CPU, SCN...
REQ-034 Reset asserted in RDATA after 1 SCN beat, then rvalid pulse -> acks 0, q 0, no command, state IDLE.
REQ-035 Stray rvalid while IDLE -> no q or ack change.
